// File: rtl/l1_bus_pkg.sv
// ---------------------------------------------------------------------------
// l1_bus_pkg
// Shared definitions for the L1 bus sequencer: FSM state encoding, client
// operation codes, the fixed line-beat bus size and the per-client operation
// priority helper.
// ---------------------------------------------------------------------------
package l1_bus_pkg;

   // FSM state encoding (also visible on the sequencer's dbg_state port).
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SINGLE  = 3'd1;
   localparam logic [2:0] ST_RL_BEAT = 3'd2;
   localparam logic [2:0] ST_WL_ADDR = 3'd3;
   localparam logic [2:0] ST_WL_DATA = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_ERR     = 3'd6;

   // Client operation codes.
   localparam logic [1:0] OP_RD = 2'd0;   // single read
   localparam logic [1:0] OP_RL = 2'd1;   // read line (refill)
   localparam logic [1:0] OP_WT = 2'd2;   // single write-through
   localparam logic [1:0] OP_WL = 2'd3;   // write line (dirty writeback)

   // Every beat of a line transfer is a full 64-bit word.
   localparam logic [3:0] LINE_SIZE = 4'b1000;

   // Priority among one client's request bits: wl > rl > rd > wt.
   // Only called for a client that requests something, so when none of the
   // higher-priority bits is set the request must be a write-through.
   function automatic logic [1:0] op_select(input logic rd, input logic rl,
                                            input logic wl);
      if (wl)      return OP_WL;
      else if (rl) return OP_RL;
      else if (rd) return OP_RD;
      else         return OP_WT;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. A lone requester always wins; on a tie
// the requester that did not win last time is granted. The last-grant
// register only moves when grant_en is high and someone is requesting, so
// the owner of a running transaction cannot be rotated out under it.
//
// Ports
//   clk, rst   clock, synchronous active-high reset (last_grant -> 1, so
//              client 0 wins the first tie)
//   req        per-requester request
//   grant_en   grant is being taken this cycle (caller is idle)
//   gnt        one-hot combinational grant (zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       grant_en,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (grant_en && (|req)) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/l1_bus_sequencer.sv
// ---------------------------------------------------------------------------
// l1_bus_sequencer
// Sequences requests from two L1 clients onto a single 64-bit system bus.
// Each client can ask for a single read, a single write-through, a cache-line
// read (refill) or a cache-line write (writeback). One transaction runs at a
// time; the losing client's request simply stays pending until IDLE.
//
// Handshake: while bus_req is high the bus fields are stable; the bus
// completes the current beat with bus_ack, or aborts the whole transaction
// with bus_err (bus_err wins over bus_ack in the same cycle). bus_ack and
// bus_err are ignored whenever bus_req is low.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_rd/rl/wt/wl [1:0]    per-client request bits (bit i = client i)
//   cl_size [7:0]            client i one-hot size at [4i+3:4i]
//   cl_pa, cl_wdata [127:0]  client i address / write data at [64i+63:64i]
//   rdata [63:0]             read data to clients
//   addr_count [10:0]        current line beat index
//   line_write, refill, trans_rdy, bus_error [1:0]  per-client pulses
//   bus_req, bus_we, bus_addr, bus_size, bus_wdata  bus master side
//   bus_ack, bus_err, bus_rdata                     bus responses
//   dbg_state [2:0]          current FSM state (l1_bus_pkg encoding)
// ---------------------------------------------------------------------------
module l1_bus_sequencer
   import l1_bus_pkg::*;
#(
   parameter int LINE_BEATS = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_rd,
   input  logic [1:0]   req_rl,
   input  logic [1:0]   req_wt,
   input  logic [1:0]   req_wl,
   input  logic [7:0]   cl_size,
   input  logic [127:0] cl_pa,
   input  logic [127:0] cl_wdata,
   output logic [63:0]  rdata,
   output logic [10:0]  addr_count,
   output logic [1:0]   line_write,
   output logic [1:0]   refill,
   output logic [1:0]   trans_rdy,
   output logic [1:0]   bus_error,
   output logic         bus_req,
   output logic         bus_we,
   output logic [63:0]  bus_addr,
   output logic [3:0]   bus_size,
   output logic [63:0]  bus_wdata,
   input  logic         bus_ack,
   input  logic         bus_err,
   input  logic [63:0]  bus_rdata,
   output logic [2:0]   dbg_state
);

   // Beat index width and the number of byte-offset bits inside one line.
   localparam int BW = $clog2(LINE_BEATS);
   localparam int LB = BW + 3;

   logic [2:0]    state_q, state_d;
   logic          g_q;          // granted client
   logic [1:0]    op_q;
   logic [63:0]   pa_q;
   logic [3:0]    size_q;
   logic [BW-1:0] beat_q;
   logic [63:0]   rdata_q;      // data captured by the last single read

   logic [1:0]    cl_req;
   logic [1:0]    gnt;
   logic          in_idle;
   logic          take_grant;
   logic          g_new;
   logic [1:0]    op_new;
   logic [63:0]   pa_new;
   logic [3:0]    size_new;
   logic [63:0]   wd_g;
   logic [1:0]    g_mask;
   logic [63:0]   line_addr;
   logic          ack_ok;
   logic          last_beat;
   logic          beat_adv;
   logic          abort;

   assign cl_req[0] = req_rd[0] | req_rl[0] | req_wt[0] | req_wl[0];
   assign cl_req[1] = req_rd[1] | req_rl[1] | req_wt[1] | req_wl[1];

   assign in_idle    = (state_q == ST_IDLE);
   assign take_grant = in_idle && (|cl_req);

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (cl_req),
      .grant_en (in_idle),
      .gnt      (gnt)
   );

   // Candidate transaction from the client the arbiter would grant now.
   assign g_new    = gnt[1];
   assign op_new   = op_select(req_rd[g_new], req_rl[g_new], req_wl[g_new]);
   assign pa_new   = g_new ? cl_pa[127:64] : cl_pa[63:0];
   assign size_new = g_new ? cl_size[7:4]  : cl_size[3:0];

   // Write data is taken live from the granted client so a line writer can
   // present a new word for each beat it sees on addr_count.
   assign wd_g   = g_q ? cl_wdata[127:64] : cl_wdata[63:0];
   assign g_mask = g_q ? 2'b10 : 2'b01;

   // Line beats walk through the line containing pa, 8 bytes per beat.
   assign line_addr = {pa_q[63:LB], beat_q, 3'b000};

   // bus_err has priority over bus_ack; both only count while bus_req is
   // high, which is exactly SINGLE, RL_BEAT and WL_DATA.
   assign ack_ok    = bus_ack && !bus_err;
   assign last_beat = (beat_q == BW'(LINE_BEATS - 1));
   assign beat_adv  = ack_ok && ((state_q == ST_RL_BEAT) || (state_q == ST_WL_DATA));
   assign abort     = bus_err && ((state_q == ST_SINGLE) || (state_q == ST_RL_BEAT) ||
                                  (state_q == ST_WL_DATA));

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (take_grant) begin
               case (op_new)
                  OP_RL:   state_d = ST_RL_BEAT;
                  OP_WL:   state_d = ST_WL_ADDR;
                  default: state_d = ST_SINGLE;
               endcase
            end
         end
         ST_SINGLE: begin
            if (bus_err)      state_d = ST_ERR;
            else if (bus_ack) state_d = ST_DONE;
         end
         ST_RL_BEAT: begin
            if (bus_err)                   state_d = ST_ERR;
            else if (bus_ack && last_beat) state_d = ST_DONE;
         end
         ST_WL_ADDR: begin
            state_d = ST_WL_DATA;
         end
         ST_WL_DATA: begin
            if (bus_err)      state_d = ST_ERR;
            else if (bus_ack) state_d = last_beat ? ST_DONE : ST_WL_ADDR;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and transaction registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         g_q     <= 1'b0;
         op_q    <= OP_RD;
         pa_q    <= '0;
         size_q  <= '0;
         beat_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (take_grant) begin
            g_q    <= g_new;
            op_q   <= op_new;
            pa_q   <= pa_new;
            size_q <= size_new;
            beat_q <= '0;
         end else if (abort) begin
            beat_q <= '0;
         end else if (beat_adv) begin
            // The final beat leaves the line state, so the counter returns
            // to zero instead of running past LINE_BEATS-1.
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
         end
         if ((state_q == ST_SINGLE) && ack_ok) begin
            rdata_q <= bus_rdata;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs. Everything is forced low while rst is high so a transfer
   // interrupted by reset produces no pulse or bus activity.
   // ------------------------------------------------------------------
   always_comb begin
      bus_req    = 1'b0;
      bus_we     = 1'b0;
      bus_addr   = '0;
      bus_size   = '0;
      bus_wdata  = '0;
      rdata      = '0;
      addr_count = '0;
      line_write = '0;
      refill     = '0;
      trans_rdy  = '0;
      bus_error  = '0;
      if (!rst) begin
         case (state_q)
            ST_SINGLE: begin
               bus_req   = 1'b1;
               bus_we    = (op_q == OP_WT);
               bus_addr  = pa_q;
               bus_size  = size_q;
               bus_wdata = wd_g;
            end
            ST_RL_BEAT: begin
               bus_req    = 1'b1;
               bus_addr   = line_addr;
               bus_size   = LINE_SIZE;
               addr_count = 11'(beat_q);
               if (ack_ok) begin
                  line_write = g_mask;
                  rdata      = bus_rdata;
               end
            end
            ST_WL_ADDR: begin
               addr_count = 11'(beat_q);
            end
            ST_WL_DATA: begin
               bus_req    = 1'b1;
               bus_we     = 1'b1;
               bus_addr   = line_addr;
               bus_size   = LINE_SIZE;
               bus_wdata  = wd_g;
               addr_count = 11'(beat_q);
            end
            ST_DONE: begin
               trans_rdy = g_mask;
               if (op_q == OP_RL) refill = g_mask;
               if (op_q == OP_RD) rdata  = rdata_q;
            end
            ST_ERR: begin
               bus_error = g_mask;
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_l1_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_l1_bus_sequencer
// Self-checking bench for l1_bus_sequencer (LINE_BEATS = 16). The bench plays
// both clients and the bus slave. For every transaction it predicts the
// granted client (round-robin over pending clients), the operation (client
// priority wl > rl > rd > wt) and the list of beat addresses, then checks
// every bus cycle and the final pulse.
// ---------------------------------------------------------------------------
module tb_l1_bus_sequencer;

   localparam int LINE_BEATS = 16;
   localparam int LINE_BYTES = LINE_BEATS * 8;
   localparam int OPC_RD = 0;
   localparam int OPC_RL = 1;
   localparam int OPC_WT = 2;
   localparam int OPC_WL = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_rd, req_rl, req_wt, req_wl;
   logic [7:0]   cl_size;
   logic [127:0] cl_pa, cl_wdata;
   logic [63:0]  rdata;
   logic [10:0]  addr_count;
   logic [1:0]   line_write, refill, trans_rdy, bus_error;
   logic         bus_req, bus_we;
   logic [63:0]  bus_addr;
   logic [3:0]   bus_size;
   logic [63:0]  bus_wdata;
   logic         bus_ack, bus_err;
   logic [63:0]  bus_rdata;
   logic [2:0]   dbg_state;

   l1_bus_sequencer #(.LINE_BEATS(LINE_BEATS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_rd     (req_rd),
      .req_rl     (req_rl),
      .req_wt     (req_wt),
      .req_wl     (req_wl),
      .cl_size    (cl_size),
      .cl_pa      (cl_pa),
      .cl_wdata   (cl_wdata),
      .rdata      (rdata),
      .addr_count (addr_count),
      .line_write (line_write),
      .refill     (refill),
      .trans_rdy  (trans_rdy),
      .bus_error  (bus_error),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_size   (bus_size),
      .bus_wdata  (bus_wdata),
      .bus_ack    (bus_ack),
      .bus_err    (bus_err),
      .bus_rdata  (bus_rdata),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int model_last = 1;              // client granted last (reset: client 1)
   logic [63:0] exp_q[$];           // expected beat addresses of current txn

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_bus"}, {59'd0, bus_req, bus_size}, 64'd0);
      chk({nm, "_we"}, 64'(bus_we), 64'd0);
      chk({nm, "_addr"}, bus_addr, 64'd0);
      chk({nm, "_wdata"}, bus_wdata, 64'd0);
      chk({nm, "_rdata"}, rdata, 64'd0);
      chk({nm, "_cnt"}, 64'(addr_count), 64'd0);
      chk({nm, "_pulses"}, 64'({line_write, refill, trans_rdy, bus_error}), 64'd0);
   endtask

   // ---------------- driver tasks ----------------
   // mask = {wl, rl, rd, wt}
   task automatic set_req(input int c, input logic [3:0] mask, input logic [63:0] pa,
                          input logic [3:0] size, input logic [63:0] wd);
      req_wl[c] = mask[3];
      req_rl[c] = mask[2];
      req_rd[c] = mask[1];
      req_wt[c] = mask[0];
      cl_pa[c*64 +: 64]    = pa;
      cl_size[c*4 +: 4]    = size;
      cl_wdata[c*64 +: 64] = wd;
   endtask

   task automatic clear_req(input int c);
      req_wl[c] = 1'b0;
      req_rl[c] = 1'b0;
      req_rd[c] = 1'b0;
      req_wt[c] = 1'b0;
   endtask

   // One idle cycle: no bus activity, no pulses, FSM in IDLE (encoding 0).
   task automatic step_idle(input string nm);
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      #1;
      chk({nm, "_state"}, 64'(dbg_state), 64'd0);
      chk({nm, "_bus_req"}, 64'(bus_req), 64'd0);
      chk({nm, "_pulses"}, 64'({line_write, refill, trans_rdy, bus_error}), 64'd0);
   endtask

   function automatic int pick_op(input logic [3:0] mask);
      if (mask[3])      return OPC_WL;
      else if (mask[2]) return OPC_RL;
      else if (mask[1]) return OPC_RD;
      else              return OPC_WT;
   endfunction

   // Called from an IDLE cycle whose requests grant client c. Plays the bus
   // slave for the whole transaction and checks every cycle up to and
   // including the DONE/ERR pulse (or the cycle after a reset abort).
   task automatic expect_txn(input int c, input int op, input logic [63:0] base,
                             input logic [3:0] size, input logic [63:0] wd,
                             input int gap_max, input int err_beat, input int rst_beat);
      int nb, gap;
      logic [1:0] oh;
      logic [63:0] last_r, ea, ewd;
      bit line, wr, err_hit, rst_hit, fin;
      line = (op == OPC_RL) || (op == OPC_WL);
      wr   = (op == OPC_WT) || (op == OPC_WL);
      nb   = line ? LINE_BEATS : 1;
      oh   = (c == 1) ? 2'b10 : 2'b01;
      model_last = c;
      err_hit = 1'b0;
      rst_hit = 1'b0;
      last_r  = '0;
      exp_q.delete();
      for (int n = 0; n < nb; n++) exp_q.push_back(line ? base + 64'(n * 8) : base);
      for (int n = 0; n < nb && !err_hit && !rst_hit; n++) begin
         ea  = exp_q.pop_front();
         ewd = (op == OPC_WL) ? (wd ^ 64'(n)) : wd;
         if (op == OPC_WL) begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_err = 1'b0;
            cl_wdata[c*64 +: 64] = ewd;
            #1;
            chk("wl_addr_bus_req", 64'(bus_req), 64'd0);
            chk("wl_addr_count", 64'(addr_count), 64'(n));
         end
         gap = $urandom_range(gap_max, 0);
         for (int k = 0; k <= gap; k++) begin
            fin = (k == gap);
            @(negedge clk);
            bus_rdata = {$urandom, $urandom};
            if (fin && n == rst_beat) begin
               rst     = 1'b1;
               bus_ack = 1'b1;
               bus_err = 1'b0;
               rst_hit = 1'b1;
            end else begin
               bus_err = fin && (n == err_beat);
               bus_ack = fin ? (bus_err ? 1'($urandom_range(1, 0)) : 1'b1) : 1'b0;
               #1;
               chk("bus_req", 64'(bus_req), 64'd1);
               chk("bus_we", 64'(bus_we), 64'(wr));
               chk("bus_addr", bus_addr, ea);
               chk("bus_size", 64'(bus_size), line ? 64'h8 : 64'(size));
               if (wr) chk("bus_wdata", bus_wdata, ewd);
               if (line) chk("addr_count", 64'(addr_count), 64'(n));
               if (fin && !bus_err && op == OPC_RL) begin
                  chk("line_write", 64'(line_write), 64'(oh));
                  chk("rl_rdata", rdata, bus_rdata);
               end else begin
                  chk("line_write_idle", 64'(line_write), 64'd0);
               end
               chk("busy_pulses", 64'({trans_rdy, refill, bus_error}), 64'd0);
               if (fin && bus_err) err_hit = 1'b1;
               if (fin && op == OPC_RD) last_r = bus_rdata;
            end
         end
      end
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (rst_hit) begin
         rst = 1'b0;
         model_last = 1;
         #1;
         chk("rst_state", 64'(dbg_state), 64'd0);
         chk_quiet("rst_out");
      end else begin
         clear_req(c);
         #1;
         chk("end_bus_req", 64'(bus_req), 64'd0);
         chk("end_line_write", 64'(line_write), 64'd0);
         if (err_hit) begin
            chk("bus_error", 64'(bus_error), 64'(oh));
            chk("err_trans_rdy", 64'(trans_rdy), 64'd0);
            chk("err_refill", 64'(refill), 64'd0);
         end else begin
            chk("trans_rdy", 64'(trans_rdy), 64'(oh));
            chk("refill", 64'(refill), (op == OPC_RL) ? 64'(oh) : 64'd0);
            chk("done_bus_error", 64'(bus_error), 64'd0);
            if (op == OPC_RD) chk("rd_data", rdata, last_r);
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          client;
      logic [3:0]  mask;      // {wl, rl, rd, wt}
      logic [63:0] pa;
      logic [3:0]  size;
      logic [63:0] wd;
      int          exp_op;
      logic [63:0] exp_base;  // first beat address
   } vec_t;

   vec_t tbl[7];

   // ---------------- main sequence ----------------
   initial begin
      bit          pend[2];
      logic [3:0]  pmask[2];
      logic [63:0] ppa[2], pwd[2];
      logic [3:0]  psize[2];
      int          g, op, eb;
      logic [63:0] base;

      tbl[0] = '{0, 4'b0010, 64'h0000_1234_5678_9ab0, 4'b0001, 64'h1111_2222_3333_4444, OPC_RD, 64'h0000_1234_5678_9ab0};
      tbl[1] = '{1, 4'b0001, 64'hdead_beef_0000_0008, 4'b1000, 64'hcafe_f00d_0123_4567, OPC_WT, 64'hdead_beef_0000_0008};
      tbl[2] = '{0, 4'b0011, 64'h0000_0000_0000_0100, 4'b0010, 64'h5555_aaaa_5555_aaaa, OPC_RD, 64'h0000_0000_0000_0100};
      tbl[3] = '{1, 4'b0111, 64'h0000_0000_0000_3057, 4'b0001, 64'h0, OPC_RL, 64'h0000_0000_0000_3000};
      tbl[4] = '{0, 4'b1100, 64'h0000_0000_0000_40ff, 4'b0001, 64'h7777_0000_7777_0000, OPC_WL, 64'h0000_0000_0000_4080};
      tbl[5] = '{1, 4'b0001, 64'h0abc_0000_0000_0010, 4'b0100, 64'h0f0f_0f0f_f0f0_f0f0, OPC_WT, 64'h0abc_0000_0000_0010};
      tbl[6] = '{0, 4'b1111, 64'h0000_0000_0000_1000, 4'b0010, 64'h9999_8888_7777_6666, OPC_WL, 64'h0000_0000_0000_1000};

      // clock/reset
      rst = 1'b1;
      req_rd = '0; req_rl = '0; req_wt = '0; req_wl = '0;
      cl_size = '0; cl_pa = '0; cl_wdata = '0;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_quiet("in_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_state", 64'(dbg_state), 64'd0);
      chk_quiet("after_reset");

      // Tie after reset: client 0 first; each client re-raises after being
      // served, so every IDLE sees a tie and the grant alternates 0,1,0,1.
      set_req(0, 4'b0010, 64'h0000_0000_0000_0a00, 4'b1000, 64'h0);
      set_req(1, 4'b0010, 64'h0000_0000_0000_0b00, 4'b0100, 64'h0);
      expect_txn(0, OPC_RD, 64'h0a00, 4'b1000, 64'h0, 1, -1, -1);
      step_idle("tie1");
      set_req(0, 4'b0010, 64'h0000_0000_0000_0a08, 4'b1000, 64'h0);
      expect_txn(1, OPC_RD, 64'h0b00, 4'b0100, 64'h0, 1, -1, -1);
      step_idle("tie2");
      set_req(1, 4'b0010, 64'h0000_0000_0000_0b08, 4'b0100, 64'h0);
      expect_txn(0, OPC_RD, 64'h0a08, 4'b1000, 64'h0, 1, -1, -1);
      step_idle("tie3");
      expect_txn(1, OPC_RD, 64'h0b08, 4'b0100, 64'h0, 1, -1, -1);

      // Table-driven single-client transactions and op priority.
      for (int i = 0; i < 7; i++) begin
         step_idle("tbl_idle");
         set_req(tbl[i].client, tbl[i].mask, tbl[i].pa, tbl[i].size, tbl[i].wd);
         expect_txn(tbl[i].client, tbl[i].exp_op, tbl[i].exp_base, tbl[i].size,
                    tbl[i].wd, 1, -1, -1);
      end

      // Read line, ack every cycle: 16 beats from 0x1000.
      step_idle("rl_idle");
      set_req(0, 4'b0100, 64'h1000, 4'b0001, 64'h0);
      expect_txn(0, OPC_RL, 64'h1000, 4'b0001, 64'h0, 0, -1, -1);

      // Write line from client 1 at 0x2040 -> line base 0x2000.
      step_idle("wl_idle");
      set_req(1, 4'b1000, 64'h2040, 4'b0001, 64'h0123_4567_89ab_cdef);
      expect_txn(1, OPC_WL, 64'h2000, 4'b0001, 64'h0123_4567_89ab_cdef, 0, -1, -1);
      step_idle("wl_after1");
      step_idle("wl_after2");  // request dropped: no spurious new grant

      // Read line aborted by bus_err on beat 5.
      set_req(0, 4'b0100, 64'h1000, 4'b0001, 64'h0);
      expect_txn(0, OPC_RL, 64'h1000, 4'b0001, 64'h0, 1, 5, -1);
      step_idle("err_after");

      // Reset during beat 7 of a read line, then the held request restarts.
      set_req(0, 4'b0100, 64'h5000, 4'b0001, 64'h0);
      expect_txn(0, OPC_RL, 64'h5000, 4'b0001, 64'h0, 0, -1, 7);
      expect_txn(0, OPC_RL, 64'h5000, 4'b0001, 64'h0, 0, -1, -1);

      // Randomized traffic against the transaction-level model.
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      repeat (30) begin
         step_idle("rnd_idle");
         for (int c = 0; c < 2; c++) begin
            if (!pend[c] && $urandom_range(1, 0) == 1) begin
               pmask[c] = 4'($urandom_range(15, 1));
               ppa[c]   = {$urandom, $urandom};
               psize[c] = 4'(1 << $urandom_range(3, 0));
               pwd[c]   = {$urandom, $urandom};
               set_req(c, pmask[c], ppa[c], psize[c], pwd[c]);
               pend[c]  = 1'b1;
            end
         end
         if (!pend[0] && !pend[1]) begin
            g = $urandom_range(1, 0);
            pmask[g] = 4'b0010;
            ppa[g]   = {$urandom, $urandom};
            psize[g] = 4'b1000;
            pwd[g]   = {$urandom, $urandom};
            set_req(g, pmask[g], ppa[g], psize[g], pwd[g]);
            pend[g]  = 1'b1;
         end
         if (pend[0] && pend[1]) g = 1 - model_last;
         else                    g = pend[1] ? 1 : 0;
         op = pick_op(pmask[g]);
         if (op == OPC_RL || op == OPC_WL) begin
            base = ppa[g] - (ppa[g] % LINE_BYTES);
            eb = ($urandom_range(7, 0) == 0) ? int'($urandom_range(LINE_BEATS - 1, 0)) : -1;
         end else begin
            base = ppa[g];
            eb = ($urandom_range(7, 0) == 0) ? 0 : -1;
         end
         expect_txn(g, op, base, psize[g], pwd[g], 2, eb, -1);
         pend[g] = 1'b0;
      end
      step_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
